generic_bus_arbiter: RTL and testbench

Round-robin arbiter that multiplexes NUM_REQ requestor-side generic bus ports onto one generic bus slave port (RAM or bus bridge). It generalises the single-master generic bus connection to a parametrised channel count, address width and data width. It holds a grant for the full duration of one transaction, and it rotates priority after every completed transaction so that no requestor starves.

---
 rtl/generic_bus_arb_pkg.sv | 17 +
 rtl/rr_priority_picker.sv | 32 +++
 rtl/generic_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_generic_bus_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/generic_bus_arb_pkg.sv
// Shared types and width helpers for the generic bus arbiters.
// Contents: arb_state_t FSM encoding, gen_bus_arb_idx_w() index-width helper.
// No logic; imported by the arbiter top and the priority picker.
package generic_bus_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Width of an index able to address n channels; never narrower than 1 bit
  // so single-entry instances still get a legal vector.
  function automatic int gen_bus_arb_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating find-first: returns the first set req bit searching ptr, ptr+1, ... mod N.
// Ports: req[N] requests, ptr start index; found = any request, idx = winning index.
// Purely combinational, zero latency, no backpressure.
module rr_priority_picker
  import generic_bus_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int W = gen_bus_arb_idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      // Explicit wrap so non-power-of-two N never visits a phantom index.
      cand = (cand == W'(N - 1)) ? '0 : cand + W'(1);
    end
  end

endmodule

// File: rtl/generic_bus_arbiter.sv
// Round-robin arbiter folding NUM_REQ generic bus masters onto one generic bus slave.
// Latency: one IDLE arbitration cycle before each transaction; bus_* then forward
// the granted channel combinationally. Backpressure: bus_busy is returned only to
// the granted channel; every other channel sees req_busy=1 and simply holds.
// Ports: clk/rst; req_* packed per channel (channel i at [i*W +: W]); req_rdata
// broadcast; bus_* slave side.
module generic_bus_arbiter
  import generic_bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*BE_W-1:0]   req_byte_en,
  input  logic [NUM_REQ-1:0]        req_ren,
  input  logic [NUM_REQ-1:0]        req_wen,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_busy,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  output logic [BE_W-1:0]           bus_byte_en,
  output logic                      bus_ren,
  output logic                      bus_wen,
  input  logic [DATA_W-1:0]         bus_rdata,
  input  logic                      bus_busy
);

  localparam int IDX_W = gen_bus_arb_idx_w(NUM_REQ);

  arb_state_t       state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] ptr;

  logic [ADDR_W-1:0] ch_addr  [NUM_REQ];
  logic [DATA_W-1:0] ch_wdata [NUM_REQ];
  logic [BE_W-1:0]   ch_be    [NUM_REQ];
  logic [NUM_REQ-1:0] ch_req;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             g_ren;
  logic             g_wen;
  logic             g_active;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign ch_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign ch_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
    assign ch_be[i]    = req_byte_en[i*BE_W +: BE_W];
  end

  assign ch_req    = req_ren | req_wen;
  assign req_rdata = bus_rdata;

  rr_priority_picker #(
    .N(NUM_REQ)
  ) u_pick (
    .req  (ch_req),
    .ptr  (ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  assign g_ren    = req_ren[grant];
  assign g_wen    = req_wen[grant];
  assign g_active = (state == ARB_GRANT) && (g_ren || g_wen);

  // Outputs are decoded from state, which resets asynchronously, so strobes
  // drop the moment rst rises rather than at the next clock.
  always_comb begin
    bus_addr    = '0;
    bus_wdata   = '0;
    bus_byte_en = '0;
    bus_ren     = 1'b0;
    bus_wen     = 1'b0;
    req_busy    = '1;
    if (state == ARB_GRANT) begin
      req_busy[grant] = bus_busy;
    end
    if (g_active) begin
      bus_addr    = ch_addr[grant];
      bus_wdata   = ch_wdata[grant];
      bus_byte_en = ch_be[grant];
      bus_wen     = g_wen;
      // A channel asserting both strobes is treated as a write.
      bus_ren     = g_ren && !g_wen;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            state <= ARB_GRANT;
            grant <= pick_idx;
          end
        end
        ARB_GRANT: begin
          if (!(g_ren || g_wen)) begin
            // Master withdrew: release the bus but keep its priority slot.
            state <= ARB_IDLE;
          end else if (!bus_busy) begin
            state <= ARB_IDLE;
            ptr   <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Directed bench for generic_bus_arbiter (NUM_REQ=4, 32-bit address/data).
// Inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_generic_bus_arbiter;
  import generic_bus_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk;
  logic            rst;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*BW-1:0] req_byte_en;
  logic [N-1:0]    req_ren;
  logic [N-1:0]    req_wen;
  logic [DW-1:0]   req_rdata;
  logic [N-1:0]    req_busy;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [BW-1:0]   bus_byte_en;
  logic            bus_ren;
  logic            bus_wen;
  logic [DW-1:0]   bus_rdata;
  logic            bus_busy;

  int n_checks;
  int n_errors;

  generic_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_byte_en(req_byte_en),
    .req_ren    (req_ren),
    .req_wen    (req_wen),
    .req_rdata  (req_rdata),
    .req_busy   (req_busy),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byte_en(bus_byte_en),
    .bus_ren    (bus_ren),
    .bus_wen    (bus_wen),
    .bus_rdata  (bus_rdata),
    .bus_busy   (bus_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic ren, input logic wen,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [BW-1:0] be);
    req_ren[ch]              = ren;
    req_wen[ch]              = wen;
    req_addr[ch*AW +: AW]    = addr;
    req_wdata[ch*DW +: DW]   = wdata;
    req_byte_en[ch*BW +: BW] = be;
  endtask

  task automatic clr_all();
    req_ren     = '0;
    req_wen     = '0;
    req_addr    = '0;
    req_wdata   = '0;
    req_byte_en = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_seq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus_busy  = 1'b0;
    bus_rdata = '0;
    clr_all();

    // ---------------- reset state
    next_cyc();
    @(negedge clk);
    check("rst_bus_ren", bus_ren, 0);
    check("rst_bus_wen", bus_wen, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_req_busy", req_busy, 4'hF);
    check("rst_ptr", dut.ptr, 0);
    next_cyc();
    rst = 1'b0;

    // ---------------- single read on ch2
    set_ch(2, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    bus_rdata = 32'hCAFE_0001;
    @(negedge clk);
    check("rd_idle_ren", bus_ren, 0);
    check("rd_idle_busy", req_busy, 4'hF);
    next_cyc();
    @(negedge clk);
    check("rd_bus_ren", bus_ren, 1);
    check("rd_bus_addr", bus_addr, 32'h100);
    check("rd_req_busy", req_busy, 4'b1011);
    check("rd_rdata", req_rdata, 32'hCAFE_0001);
    next_cyc();
    clr_all();
    @(negedge clk);
    check("rd_after_ren", bus_ren, 0);
    check("rd_ptr", dut.ptr, 3);

    // ---------------- ch0 and ch1 together (ptr=3 -> 0 first, then 1)
    set_ch(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_ch(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    next_cyc();
    @(negedge clk);
    check("sim_g0_addr", bus_addr, 32'h10);
    check("sim_g0_busy", req_busy, 4'b1110);
    next_cyc();
    set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("sim_gap_ren", bus_ren, 0);
    check("sim_gap_busy", req_busy, 4'hF);
    next_cyc();
    @(negedge clk);
    check("sim_g1_addr", bus_addr, 32'h20);
    check("sim_g1_busy", req_busy, 4'b1101);
    next_cyc();
    clr_all();
    @(negedge clk);
    check("sim_ptr", dut.ptr, 2);

    // ---------------- fairness from ptr=0, slave busy for 2 cycles each
    rst = 1'b1;
    bus_busy = 1'b1;
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b0, 32'h1000 + c, 32'h0, 4'h0);
    next_cyc();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("fair%0d_idle", k), bus_ren, 0);
      next_cyc();
      @(negedge clk);
      check($sformatf("fair%0d_addr", k), bus_addr, 32'h1000 + exp_seq[k]);
      check($sformatf("fair%0d_hold", k), req_busy, 4'hF);
      next_cyc();
      next_cyc();
      bus_busy = 1'b0;
      @(negedge clk);
      check($sformatf("fair%0d_done", k), req_busy, 4'hF & ~(4'b1 << exp_seq[k]));
      next_cyc();
      bus_busy = 1'b1;
    end
    clr_all();
    check("fair_ptr", dut.ptr, 2);

    // ---------------- write precedence with byte enables on ch1
    bus_busy = 1'b0;
    set_ch(1, 1'b1, 1'b1, 32'h44, 32'hDEAD_BEEF, 4'b0011);
    next_cyc();
    @(negedge clk);
    check("wr_wen", bus_wen, 1);
    check("wr_ren", bus_ren, 0);
    check("wr_be", bus_byte_en, 4'b0011);
    check("wr_wdata", bus_wdata, 32'hDEAD_BEEF);
    check("wr_busy", req_busy, 4'b1101);
    next_cyc();
    clr_all();
    @(negedge clk);
    check("wr_ptr", dut.ptr, 2);

    // ---------------- abort: ch3 drops wen while slave busy
    bus_busy = 1'b1;
    set_ch(3, 1'b0, 1'b1, 32'h3C, 32'h5555_AAAA, 4'hF);
    next_cyc();
    @(negedge clk);
    check("ab_wen_on", bus_wen, 1);
    check("ab_addr", bus_addr, 32'h3C);
    req_wen[3] = 1'b0;
    #1;
    check("ab_wen_drop", bus_wen, 0);
    check("ab_addr_zero", bus_addr, 0);
    next_cyc();
    check("ab_state", dut.state, 64'(ARB_IDLE));
    check("ab_ptr", dut.ptr, 2);
    clr_all();

    // ---------------- reset during a granted read on ch1
    set_ch(1, 1'b1, 1'b0, 32'h11, 32'h0, 4'h0);
    next_cyc();
    @(negedge clk);
    check("rs_ren_on", bus_ren, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rs_ren_async", bus_ren, 0);
    check("rs_busy_async", req_busy, 4'hF);
    next_cyc();
    rst = 1'b0;
    set_ch(3, 1'b1, 1'b0, 32'h33, 32'h0, 4'h0);
    next_cyc();
    @(negedge clk);
    check("rs_first_ch1", bus_addr, 32'h11);
    bus_busy = 1'b0;
    next_cyc();
    set_ch(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cyc();
    @(negedge clk);
    check("rs_then_ch3", bus_addr, 32'h33);
    check("rs_ch3_busy", req_busy, 4'b0111);
    next_cyc();
    clr_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
